// File: rtl/biu_prefetch_pkg.sv
// ============================================================================
// biu_prefetch_pkg : state encodings, reset vector and physical address helper
// Rev 1.0
// ============================================================================
`default_nettype none

package biu_prefetch_pkg;

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_EU    = 2'd1;
   localparam logic [1:0] ST_TURN  = 2'd2;

   localparam logic [15:0] RESET_CS = 16'hF000;
   localparam logic [15:0] RESET_IP = 16'h0000;

   function automatic logic [19:0] phys_addr(input logic [15:0] seg, input logic [15:0] off);
      return {seg, 4'h0} + {4'h0, off};
   endfunction

endpackage

`default_nettype wire

// File: rtl/biu_queue.sv
// ============================================================================
// biu_queue : circular byte FIFO with 0/1/2-byte push, 1-byte pop
// Rev 1.0
// ============================================================================
`default_nettype none

module biu_queue #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             en,
   input  logic             clear,
   input  logic [1:0]       push_n,
   input  logic [7:0]       push_d0,
   input  logic [7:0]       push_d1,
   input  logic             pop,
   output logic [7:0]       head,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + PTR_W'(1);
   endfunction

   logic [7:0]       r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd;
   logic [PTR_W-1:0] r_wr;
   logic [CNT_W-1:0] r_count;
   logic [PTR_W-1:0] w_wr1;
   logic [PTR_W-1:0] w_wr2;
   logic             w_pop;

   assign w_wr1 = ptr_inc(r_wr);
   assign w_wr2 = ptr_inc(w_wr1);
   assign w_pop = pop && (r_count != '0);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else if (en) begin
         if (clear) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
         end else begin
            if (w_pop)
               r_rd <= ptr_inc(r_rd);
            if (push_n == 2'd1)
               r_wr <= w_wr1;
            else if (push_n == 2'd2)
               r_wr <= w_wr2;
            r_count <= r_count + CNT_W'(push_n) - CNT_W'(w_pop);
         end
      end
   end

   // Storage needs no reset: count gates every read of it.
   always_ff @(posedge clock) begin
      if (en && !clear) begin
         if (push_n != 2'd0)
            r_mem[r_wr] <= push_d0;
         if (push_n == 2'd2)
            r_mem[w_wr1] <= push_d1;
      end
   end

   assign head  = r_mem[r_rd];
   assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/biu_prefetch.sv
// ============================================================================
// biu_prefetch : bus interface unit sharing one memory port between
//                instruction prefetch and EU data transfers
// Rev 1.0
// ============================================================================
`default_nettype none

module biu_prefetch
   import biu_prefetch_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 4
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              locked,
   output logic [19:0]       address,
   input  logic [DATA_W-1:0] bus,
   output logic [DATA_W-1:0] data,
   output logic              wreq,
   input  logic              flush,
   input  logic [15:0]       flush_cs,
   input  logic [15:0]       flush_ip,
   output logic [7:0]        q_data,
   output logic [15:0]       q_ip,
   output logic [CNT_W-1:0]  q_count,
   input  logic              q_pop,
   input  logic              eu_req,
   input  logic              eu_we,
   input  logic [19:0]       eu_addr,
   input  logic [7:0]        eu_wdata,
   output logic [7:0]        eu_rdata,
   output logic              eu_ack
);

   localparam int BYTES = DATA_W / 8;

   logic [1:0]  r_state;
   logic [1:0]  w_next_state;
   logic [15:0] r_cs;
   logic [15:0] r_fetch_ip;
   logic [15:0] r_q_ip;
   logic [7:0]  r_eu_rdata;

   logic        w_eu_bus;
   logic        w_room1;
   logic        w_room2;
   logic [1:0]  w_fetch_n;
   logic [1:0]  w_push_n;
   logic [7:0]  w_d0;
   logic [7:0]  w_d1;
   logic [7:0]  w_lane;

   assign w_room1 = q_count < CNT_W'(DEPTH);
   assign w_room2 = q_count < CNT_W'(DEPTH - 1);

   generate
      if (DATA_W == 16) begin : g_bus16
         // Odd offsets fetch only the high lane so the next fetch is word aligned.
         assign w_fetch_n = r_fetch_ip[0] ? (w_room1 ? 2'd1 : 2'd0)
                                          : (w_room2 ? 2'd2 : 2'd0);
         assign w_d0      = r_fetch_ip[0] ? bus[DATA_W-1 -: 8] : bus[7:0];
         assign w_d1      = bus[DATA_W-1 -: 8];
         assign w_lane    = eu_addr[0] ? bus[DATA_W-1 -: 8] : bus[7:0];
      end else begin : g_bus8
         assign w_fetch_n = w_room1 ? 2'd1 : 2'd0;
         assign w_d0      = bus[7:0];
         assign w_d1      = bus[7:0];
         assign w_lane    = bus[7:0];
      end
   endgenerate

   // State register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         r_state <= ST_FETCH;
      else if (locked)
         r_state <= w_next_state;
   end

   // Next-state logic
   always_comb begin
      w_next_state = ST_FETCH;
      case (r_state)
         ST_FETCH: w_next_state = eu_req ? ST_EU : ST_FETCH;
         ST_EU:    w_next_state = ST_TURN;
         ST_TURN:  w_next_state = ST_FETCH;
         default:  w_next_state = ST_FETCH;
      endcase
   end

   // Output logic
   always_comb begin
      w_eu_bus = (r_state == ST_EU) || ((r_state == ST_FETCH) && eu_req);
      address  = w_eu_bus ? eu_addr : phys_addr(r_cs, r_fetch_ip);
      wreq     = 1'b0;
      data     = '0;
      eu_ack   = (r_state == ST_TURN);
      w_push_n = w_eu_bus ? 2'd0 : w_fetch_n;
      if ((r_state == ST_EU) && eu_we) begin
         wreq = 1'b1;
         data = {BYTES{eu_wdata}};
      end
   end

   // Flush wins over fetch advance and pop; the queue drops the push itself.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_cs       <= RESET_CS;
         r_fetch_ip <= RESET_IP;
         r_q_ip     <= RESET_IP;
         r_eu_rdata <= 8'h00;
      end else if (locked) begin
         if (flush) begin
            r_cs       <= flush_cs;
            r_fetch_ip <= flush_ip;
            r_q_ip     <= flush_ip;
         end else begin
            r_fetch_ip <= r_fetch_ip + 16'(w_push_n);
            if (q_pop && (q_count != '0))
               r_q_ip <= r_q_ip + 16'd1;
         end
         if ((r_state == ST_EU) && !eu_we)
            r_eu_rdata <= w_lane;
      end
   end

   biu_queue #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_queue (
      .clock   (clock),
      .resetn  (resetn),
      .en      (locked),
      .clear   (flush),
      .push_n  (w_push_n),
      .push_d0 (w_d0),
      .push_d1 (w_d1),
      .pop     (q_pop),
      .head    (q_data),
      .count   (q_count)
   );

   assign q_ip     = r_q_ip;
   assign eu_rdata = r_eu_rdata;

endmodule

`default_nettype wire
